// File: rtl/neuron_seq.sv
// neuron_seq: single-neuron sequencer. One signed DW x DW multiply-accumulate
// unit is time-shared across N_INPUTS input/weight pairs. The result is bias
// plus the dot product, with optional ReLU, and is returned over valid/ready.
// Weights live in a local register file that can only be written while idle.
module neuron_seq #(
  parameter int N_INPUTS = 4,
  parameter int DW       = 8,
  parameter int AW       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [$clog2(N_INPUTS)-1:0] cfg_addr,
  input  logic [DW-1:0]               cfg_wdata,
  input  logic                        start,
  input  logic [AW-1:0]               bias,
  input  logic                        relu_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AW-1:0]               out_data,
  output logic                        busy
);

  localparam int IW = $clog2(N_INPUTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   acc_q;
  logic [IW-1:0]   idx_q;
  logic            relu_q;
  logic [AW-1:0]   out_data_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [DW-1:0]   w_q [N_INPUTS];

  logic [AW-1:0]   prod_d;
  logic [AW-1:0]   sum_d;
  logic [AW-1:0]   result_d;
  logic            cfg_in_range;

  // MAC datapath: full-width signed product, accumulator wraps modulo 2^AW.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    prod_d       = '0;
    sum_d        = '0;
    result_d     = '0;
    cfg_in_range = 1'b0;
    prod_d       = AW'($signed(in_data)) * AW'($signed(w_q[idx_q]));
    sum_d        = acc_q + prod_d;
    result_d     = (relu_q && sum_d[AW-1]) ? '0 : sum_d;
    cfg_in_range = (int'(cfg_addr) < N_INPUTS);
  end

  // Sequencer FSM with registered handshake outputs and the weight file.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      // NOTE: the weight file is small and must read as zero after reset,
      // so it is reset like any other register rather than left as a RAM.
      for (int i = 0; i < N_INPUTS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_we && cfg_in_range) begin
            w_q[cfg_addr] <= cfg_wdata;
          end
          if (start) begin
            acc_q      <= bias;
            relu_q     <= relu_en;
            idx_q      <= '0;
            state_q    <= ACCUM;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            acc_q <= sum_d;
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              out_data_q  <= result_d;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: doc/neuron_seq.md
Name: neuron_seq

Overview:
- Single-neuron sequencer. Time-multiplexes one signed 8x8 multiply-accumulate unit across N_INPUTS input/weight pairs.
- Adds a bias, optionally applies ReLU, and returns one 16-bit result per run over a valid/ready handshake.
- Sits between the input stream source and the downstream layer logic.
- Holds its own weight register file, which is loaded through a configuration write port while idle.

Parameters:
- N_INPUTS, 4, number of input/weight pairs per neuron evaluation (>=2).
- DW, 8, signed width of inputs and weights.
- AW, 16, signed accumulator/output width (2*DW).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  weight write strobe
- cfg_addr  in  $clog2(N_INPUTS)  weight index
- cfg_wdata  in  DW  signed weight value
- start  in  1  begin one evaluation (single-cycle pulse)
- bias  in  AW  signed bias, sampled on accepted start
- relu_en  in  1  ReLU enable, sampled on accepted start
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer accepts input
- in_data  in  DW  signed input sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  AW  signed result
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state):
  - state=IDLE; accumulator=0; index=0; all weights=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> acc<=bias, relu_q<=relu_en, idx<=0, go to ACCUM next cycle.
  - cfg_we=1 with cfg_addr<N_INPUTS -> weight[cfg_addr]<=cfg_wdata. Out-of-range address is ignored.
  - start and cfg_we in the same cycle: both take effect. The write lands before the first MAC step.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready: acc <= acc + in_data*weight[idx]. Product is a full 2*DW signed value; the sum wraps modulo 2^AW with no saturation. idx increments.
  - in_valid=0 -> acc and idx hold; stalls are unbounded.
  - Transfer with idx==N_INPUTS-1 -> go to DONE. out_data is registered in the same edge:
    - relu_q=1 and final sum negative -> out_data=0.
    - otherwise -> out_data=final sum.
- DONE:
  - out_valid=1; out_data is stable until the handshake completes.
  - out_valid&&out_ready -> IDLE next cycle, out_valid drops.
  - out_ready may be high before out_valid; the result is then consumed in the first DONE cycle.
- Ignored while busy: start, and cfg_we (weights are frozen during a run).
- Latency, best case (start at cycle 0, in_valid constantly high): inputs accepted in cycles 1..N_INPUTS, out_valid high in cycle N_INPUTS+1. A new start is accepted one cycle after the result handshake.
- out_data holds its last value after leaving DONE. It is cleared only by reset.
- Reset mid-run abandons the evaluation. No output is produced and the weights are cleared.

Test Plan:
- Basic run: weights {1,2,3,4}, bias=10, relu_en=0, inputs {1,1,1,1} -> out_data=20, out_valid at cycle 5 after start.
- Signed edge values: weights {-127,-127,127,2}, inputs {-127,1,127,-127}, bias=0 -> out_data=31877.
- ReLU: weights {-5,0,0,0}, inputs {3,9,9,9}, bias=0.
  - relu_en=0 -> out_data=-15 (0xFFF1).
  - relu_en=1 -> out_data=0.
- Wrap-around: all weights 127, all inputs 127, bias=0 -> out_data=-1020 (64516 mod 2^16).
- Handshake and ignore rules:
  - in_valid low for 3 cycles between samples -> result unchanged (20, per basic run).
  - out_ready held low 5 cycles -> out_valid stays 1, out_data stays stable.
  - start pulsed during ACCUM -> ignored.
  - cfg_we to addr 0 during ACCUM -> weight unchanged on the next run.
- Reset mid-run: assert rst after 2 inputs accepted -> all outputs 0, busy=0. Next run (no reload), bias=7 -> out_data=7.
